// File: rtl/wb_port_arbiter_pkg.sv
// wb_port_arbiter_pkg: shared widths, writeback entry type and arbiter state for the RF write-port arbiter.
package wb_port_arbiter_pkg;
  localparam int WD_SIZE        = 32;
  localparam int INSTR_REG_SIZE = 5;
  localparam int MQ_DEPTH_DEF   = 2;
  localparam int STARVE_MAX_DEF = 4;
  typedef struct packed {
    logic [INSTR_REG_SIZE-1:0] rd;
    logic [WD_SIZE-1:0]        data;
  } wb_entry_t;
  typedef enum logic {WB_NORMAL, WB_DRAIN} wb_state_t;
endpackage

// File: rtl/wb_port_arbiter_mq.sv
// wb_mult_queue: circular FIFO of multiplier results, exposing per-entry rd/valid for hazard compares.
module wb_mult_queue
  import wb_port_arbiter_pkg::*;
#(
  parameter int DEPTH = MQ_DEPTH_DEF
) (
  input  logic                                  clk,
  input  logic                                  reset_n,
  input  logic                                  push_i,
  input  logic                                  pop_i,
  input  wb_entry_t                             din_i,
  output wb_entry_t                             head_o,
  output logic                                  full_o,
  output logic                                  empty_o,
  output logic [$clog2(DEPTH):0]                count_o,
  output logic [DEPTH-1:0]                      valid_o,
  output logic [DEPTH-1:0][INSTR_REG_SIZE-1:0]  rd_o
);
  localparam int AW = $clog2(DEPTH);
  wb_entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  // Pop clears before push sets so push+pop on the same slot (full) keeps it valid.
  always_comb begin
    mem_d = mem_q;
    valid_d = valid_q;
    if (pop_i) valid_d[rd_ptr_q] = 1'b0;
    if (push_i) begin
      mem_d[wr_ptr_q] = din_i;
      valid_d[wr_ptr_q] = 1'b1;
    end
    wr_ptr_d = push_i ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_i ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d = count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};
    head_o = mem_q[rd_ptr_q];
    full_o = count_q == (AW+1)'(DEPTH);
    empty_o = count_q == '0;
    count_o = count_q;
    valid_o = valid_q;
    for (int i = 0; i < DEPTH; i++) rd_o[i] = mem_q[i].rd;
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end
endmodule

// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the single RF write port between mem-stage writeback and queued multiplier results.
module wb_port_arbiter
  import wb_port_arbiter_pkg::*;
#(
  parameter int MQ_DEPTH   = MQ_DEPTH_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          mem_valid_i,
  input  logic                          mem_we_i,
  input  logic                          ctrl_ld_i,
  input  logic [WD_SIZE-1:0]            alu_result_i,
  input  logic [WD_SIZE-1:0]            dmem_data_i,
  input  logic [INSTR_REG_SIZE-1:0]     rd_mem_i,
  input  logic                          mult_valid_i,
  input  logic [WD_SIZE-1:0]            mult_result_i,
  input  logic [INSTR_REG_SIZE-1:0]     rd_mult_i,
  output logic                          mult_ready_o,
  output logic                          stall_mem_o,
  output logic                          rf_we_o,
  output logic [INSTR_REG_SIZE-1:0]     rf_rd_o,
  output logic [WD_SIZE-1:0]            rf_data_o,
  output logic [$clog2(MQ_DEPTH):0]     mq_count_o,
  output logic                          overflow_o
);
  localparam int CW = $clog2(MQ_DEPTH) + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);
  wb_state_t state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic overflow_q, overflow_d;
  logic mem_req, waw, pop, push, grant_mem, full, empty;
  logic [CW-1:0] count;
  logic [MQ_DEPTH-1:0] q_valid;
  logic [MQ_DEPTH-1:0][INSTR_REG_SIZE-1:0] q_rd;
  wb_entry_t head;
  wb_mult_queue #(.DEPTH(MQ_DEPTH)) u_mq (
    .clk     (clk),
    .reset_n (reset_n),
    .push_i  (push),
    .pop_i   (pop),
    .din_i   ('{rd: rd_mult_i, data: mult_result_i}),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count),
    .valid_o (q_valid),
    .rd_o    (q_rd)
  );
  always_comb begin
    mem_req = mem_valid_i & mem_we_i & (rd_mem_i != '0);
    waw = 1'b0;
    for (int i = 0; i < MQ_DEPTH; i++) waw = waw | (mem_req & q_valid[i] & (q_rd[i] == rd_mem_i));
    pop = !empty & ((state_q == WB_DRAIN) | !mem_req | waw | full);
    grant_mem = mem_req & !pop;
    mult_ready_o = !full | pop;
    push = mult_valid_i & mult_ready_o;
    rf_we_o = reset_n & (pop | grant_mem);
    stall_mem_o = reset_n & mem_req & pop;
    rf_rd_o = pop ? head.rd : grant_mem ? rd_mem_i : '0;
    rf_data_o = pop ? head.data : grant_mem ? (ctrl_ld_i ? dmem_data_i : alu_result_i) : '0;
    starve_d = (pop | empty) ? '0 :
               (grant_mem & (starve_q != SW'(STARVE_MAX))) ? starve_q + SW'(1) : starve_q;
    // Entering drain looks at the updated counter so exactly STARVE_MAX mem grants precede it.
    state_d = (state_q == WB_NORMAL) ? ((starve_d == SW'(STARVE_MAX)) ? WB_DRAIN : WB_NORMAL) :
              (((count == CW'(1)) & pop & !push) | (count == '0)) ? WB_NORMAL : WB_DRAIN;
    overflow_d = overflow_q | (mult_valid_i & !mult_ready_o);
    mq_count_o = count;
    overflow_o = overflow_q;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= WB_NORMAL;
      starve_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      starve_q <= starve_d;
      overflow_q <= overflow_d;
    end
  end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter: directed and random stimulus against a queue-based model, writes checked by a scoreboard.
module tb_wb_port_arbiter;
  import wb_port_arbiter_pkg::*;
  localparam int D = 2;
  localparam int SM = 4;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic mem_valid_i = 0, mem_we_i = 0, ctrl_ld_i = 0, mult_valid_i = 0;
  logic [WD_SIZE-1:0] alu_result_i = 0, dmem_data_i = 0, mult_result_i = 0;
  logic [INSTR_REG_SIZE-1:0] rd_mem_i = 0, rd_mult_i = 0;
  logic mult_ready_o, stall_mem_o, rf_we_o, overflow_o;
  logic [INSTR_REG_SIZE-1:0] rf_rd_o;
  logic [WD_SIZE-1:0] rf_data_o;
  logic [$clog2(D):0] mq_count_o;
  always #5 clk = ~clk;
  wb_port_arbiter #(.MQ_DEPTH(D), .STARVE_MAX(SM)) dut (
    .clk(clk), .reset_n(reset_n), .mem_valid_i(mem_valid_i), .mem_we_i(mem_we_i),
    .ctrl_ld_i(ctrl_ld_i), .alu_result_i(alu_result_i), .dmem_data_i(dmem_data_i),
    .rd_mem_i(rd_mem_i), .mult_valid_i(mult_valid_i), .mult_result_i(mult_result_i),
    .rd_mult_i(rd_mult_i), .mult_ready_o(mult_ready_o), .stall_mem_o(stall_mem_o),
    .rf_we_o(rf_we_o), .rf_rd_o(rf_rd_o), .rf_data_o(rf_data_o),
    .mq_count_o(mq_count_o), .overflow_o(overflow_o)
  );
  typedef struct {
    logic [INSTR_REG_SIZE-1:0] rd;
    logic [WD_SIZE-1:0] data;
  } wr_t;
  wr_t exp_q[$];
  wr_t mq[$];
  bit drain = 0, ovf = 0, exp_stall = 0;
  int starve = 0;
  int n_checks = 0, n_fail = 0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask
  always @(negedge clk) if (rf_we_o === 1'b1) begin : mon
    wr_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write at %0t", rf_rd_o, rf_data_o, $time);
    end else begin
      e = exp_q.pop_front();
      chk("wr_rd", 32'(rf_rd_o), 32'(e.rd));
      chk("wr_data", rf_data_o, e.data);
    end
  end
  // One cycle: drive inputs after the edge, predict from the model, then advance the model.
  task automatic step(input bit rst, input bit mv, input bit mwe, input bit ld,
                      input logic [4:0] mrd, input logic [31:0] alu, input logic [31:0] dm,
                      input bit xv, input logic [4:0] xrd, input logic [31:0] xres);
    bit mreq, waw, full, takeq, ready, was_empty;
    @(posedge clk);
    #1;
    reset_n = !rst;
    mem_valid_i = mv; mem_we_i = mwe; ctrl_ld_i = ld; rd_mem_i = mrd;
    alu_result_i = alu; dmem_data_i = dm;
    mult_valid_i = xv; rd_mult_i = xrd; mult_result_i = xres;
    #1;
    if (rst) begin
      chk("rst_we", 32'(rf_we_o), 0);
      chk("rst_stall", 32'(stall_mem_o), 0);
      mq.delete(); drain = 0; starve = 0; ovf = 0; exp_stall = 0;
    end else begin
      mreq = mv && mwe && mrd != 0;
      waw = 0;
      foreach (mq[i]) if (mreq && mq[i].rd == mrd) waw = 1;
      full = mq.size() == D;
      takeq = mq.size() != 0 && (drain || !mreq || waw || full);
      exp_stall = mreq && takeq;
      ready = !full || takeq;
      chk("stall", 32'(stall_mem_o), 32'(exp_stall));
      chk("ready", 32'(mult_ready_o), 32'(ready));
      chk("count", 32'(mq_count_o), mq.size());
      chk("overflow", 32'(overflow_o), 32'(ovf));
      was_empty = mq.size() == 0;
      if (takeq) exp_q.push_back(mq.pop_front());
      else if (mreq) exp_q.push_back('{rd: mrd, data: ld ? dm : alu});
      if (xv && ready) mq.push_back('{rd: xrd, data: xres});
      else if (xv) ovf = 1;
      if (takeq || was_empty) starve = 0;
      else if (mreq) starve = (starve < SM) ? starve + 1 : SM;
      if (!drain && starve == SM) drain = 1;
      else if (drain && mq.size() == 0) drain = 0;
    end
  endtask
  // Issue a mem-stage write, holding it while stalled; the mult pulse goes with the first cycle only.
  task automatic mem_issue(input bit mv, input logic [4:0] mrd, input logic [31:0] alu, input bit ld,
                           input logic [31:0] dm, input bit xv, input logic [4:0] xrd, input logic [31:0] xres);
    step(0, mv, 1, ld, mrd, alu, dm, xv, xrd, xres);
    for (int k = 0; k < 8 && exp_stall; k++) step(0, mv, 1, ld, mrd, alu, dm, 0, 0, 0);
  endtask
  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    bit rmv, rmwe, rld;
    logic [4:0] rrd;
    logic [31:0] ralu, rdm;
    step(1, 1, 1, 0, 5, 32'h11, 0, 1, 2, 32'h99);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_issue(1, 5, 32'h11, 0, 32'h22, 0, 0, 0);
    mem_issue(1, 5, 32'h11, 0, 32'h22, 0, 0, 0);
    mem_issue(1, 5, 32'h11, 1, 32'h22, 0, 0, 0);
    step(0, 1, 1, 0, 0, 32'h55, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 1, 7, 32'hAB);
    idle(2);
    mem_issue(1, 4, 32'h44, 0, 0, 1, 3, 32'h333);
    mem_issue(1, 3, 32'h3A, 0, 0, 0, 0, 0);
    idle(1);
    mem_issue(1, 1, 32'h101, 0, 0, 1, 9, 32'h999);
    for (int r = 2; r < 8; r++) mem_issue(1, 5'(r + 8), 32'(r), 0, 0, 0, 0, 0);
    idle(1);
    mem_issue(1, 13, 32'hD, 0, 0, 1, 11, 32'hB0B);
    mem_issue(1, 14, 32'hE, 0, 0, 1, 12, 32'hC0C);
    mem_issue(1, 16, 32'h10, 0, 0, 1, 15, 32'hF0F);
    mem_issue(1, 17, 32'h11, 0, 0, 1, 18, 32'h1818);
    idle(3);
    step(0, 1, 1, 0, 1, 32'h1, 0, 1, 20, 32'hA20);
    step(0, 1, 1, 0, 2, 32'h2, 0, 0, 0, 0);
    step(0, 1, 1, 0, 3, 32'h3, 0, 0, 0, 0);
    step(0, 1, 1, 0, 4, 32'h4, 0, 0, 0, 0);
    step(0, 1, 1, 0, 6, 32'h6, 0, 1, 21, 32'hA21);
    step(1, 1, 1, 0, 6, 32'h6, 0, 0, 0, 0);
    idle(3);
    for (int c = 0; c < 2000; c++) begin
      if (!exp_stall) begin
        rmv = $urandom_range(0, 9) < 7;
        rmwe = $urandom_range(0, 9) < 8;
        rld = 1'($urandom_range(0, 1));
        rrd = 5'($urandom_range(0, 7));
        ralu = $urandom;
        rdm = $urandom;
      end
      step($urandom_range(0, 99) == 0, rmv, rmwe, rld, rrd, ralu, rdm,
           $urandom_range(0, 9) < 4, 5'($urandom_range(1, 7)), $urandom);
    end
    idle(4);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
